// File: rtl/rx_frame_store.sv
// Store-and-forward receive frame buffer: holds each MAC frame until its last byte,
// commits good frames with their length and replays them; bad or unfit frames are rewound away.
module rx_frame_store #(
    parameter int ADDR_W = 11,
    parameter int LQ_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_bad,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] out_len,
    output logic [15:0] frames_dropped,
    output logic        buf_full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LQ_DEPTH = 1 << LQ_W;

    logic [7:0]        mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cm_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       len;
    logic [15:0]       len_inc;
    logic              ovf;

    logic [15:0]       lq_mem [0:LQ_DEPTH-1];
    logic [LQ_W-1:0]   lq_wp;
    logic [LQ_W-1:0]   lq_rp;
    logic [LQ_W:0]     lq_cnt;
    logic              lq_full;
    logic              lq_empty;

    logic [1:0]        state;
    logic [15:0]       rem;

    logic space;
    logic wr_en;
    logic eof;
    logic commit;
    logic drop;
    logic pop;
    logic hs;
    logic rd_en;

    // Valid/ready: a byte moves on a rising clk edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_last/out_len stay put.
    assign wr_next  = wr_ptr + ADDR_W'(1);
    assign space    = (wr_next != rd_ptr);
    assign buf_full = !space;
    assign wr_en    = in_valid && space;
    assign eof      = in_valid && in_last;
    assign len_inc  = (len == 16'hFFFF) ? len : len + 16'd1;

    assign lq_full  = lq_cnt[LQ_W];
    assign lq_empty = (lq_cnt == '0);

    // The last byte must itself fit; otherwise the frame is incomplete and is dropped.
    assign commit = eof && !in_bad && !ovf && !lq_full && space;
    assign drop   = eof && !commit;

    assign pop       = (state == S_IDLE) && !lq_empty;
    assign out_valid = (state == S_SEND);
    assign out_last  = out_valid && (rem == 16'd1);
    assign hs        = out_valid && out_ready;

    // The next byte is prefetched on each handshake, except after the last one,
    // whose successor address is not committed and may be in the middle of a write.
    assign rd_en   = (state == S_FETCH) || (hs && !out_last);
    assign rd_addr = (state == S_FETCH) ? rd_ptr : rd_ptr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= 8'd0;
        end else if (rd_en) begin
            out_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            len    <= 16'd0;
            ovf    <= 1'b0;
        end else if (eof) begin
            len <= 16'd0;
            ovf <= 1'b0;
            if (commit) begin
                wr_ptr <= wr_next;
                cm_ptr <= wr_next;
            end else begin
                wr_ptr <= cm_ptr;
            end
        end else if (in_valid) begin
            if (space) begin
                wr_ptr <= wr_next;
                len    <= len_inc;
            end else begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_dropped <= 16'd0;
        end else if (drop && (frames_dropped != 16'hFFFF)) begin
            frames_dropped <= frames_dropped + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            lq_mem[lq_wp] <= len_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq_wp  <= '0;
            lq_rp  <= '0;
            lq_cnt <= '0;
        end else begin
            if (commit) begin
                lq_wp <= lq_wp + LQ_W'(1);
            end
            if (pop) begin
                lq_rp <= lq_rp + LQ_W'(1);
            end
            case ({commit, pop})
                2'b10:   lq_cnt <= lq_cnt + (LQ_W+1)'(1);
                2'b01:   lq_cnt <= lq_cnt - (LQ_W+1)'(1);
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rd_ptr  <= '0;
            rem     <= 16'd0;
            out_len <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        out_len <= lq_mem[lq_rp];
                        rem     <= lq_mem[lq_rp];
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                        rem    <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rx_frame_store.md
# rx_frame_store

Store-and-forward frame buffer between the receive side of `mac_controller` and the transmit controller. It accepts the MAC receive byte stream and holds each frame until its last byte. Good frames are committed and later replayed with their byte length. Bad, overflowed or unqueueable frames are erased by rewinding the write pointer, so the downstream stage only ever sees complete, good frames with a known length.

## Interface
- `ADDR_W`, 11: data RAM address width; capacity 2^ADDR_W bytes, usable 2^ADDR_W−1.
- `LQ_W`, 3: length-queue address width; up to 2^LQ_W committed frames queued.
- `clk`  in  1  single clock for everything (MAC rx clock domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_last`  in  1  final byte of frame; qualified by `in_valid`.
- `in_bad`  in  1  frame error (CRC/PHY); sampled only with `in_valid && in_last`.
- `out_data`  out  8  replayed byte.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  final byte of current frame.
- `out_ready`  in  1  consumer accepts byte.
- `out_len`  out  16  byte count of frame being replayed; stable from first `out_valid` to last handshake.
- `frames_dropped`  out  16  saturating count of discarded frames.
- `buf_full`  out  1  data RAM has no free byte.

## Operation
- **Pointers.** `ADDR_W`-bit `wr_ptr`, `cm_ptr` (committed end) and `rd_ptr`, all wrap modulo 2^ADDR_W.
  - Free-byte test: `wr_ptr+1 != rd_ptr`.
  - `buf_full` = !free.
- **Write side, per frame.** Flags `ovf` and 16-bit `len`.
  - On each `in_valid` byte with space: write RAM[`wr_ptr`], `wr_ptr++`, `len++` (saturates at 0xFFFF).
  - On an `in_valid` byte without space: byte discarded, `ovf`←1.
- **End of frame** (`in_valid && in_last`, with the last byte itself written if space):
  - Commit when `!in_bad && !ovf && !lq_full && no overflow on this byte`.
    - `cm_ptr`←new `wr_ptr`.
    - Push `len` (including the last byte) into the length queue.
  - Otherwise drop.
    - `wr_ptr`←`cm_ptr`.
    - `frames_dropped++` (saturates at 0xFFFF).
  - Either way, `len`←0 and `ovf`←0.
- **Length queue.** FIFO of 2^LQ_W × 16 bits.
  - Push and pop in the same cycle leaves the count unchanged.
  - Push when full never happens because that frame is dropped.
- **Read FSM.**
  - IDLE: if the length queue is non-empty → pop into `out_len`, load `rem`←`out_len`, issue RAM read at `rd_ptr` → FETCH.
  - FETCH: RAM data registers into `out_data` → SEND.
  - SEND: `out_valid`=1, `out_last`=(`rem`==1).
    - On handshake: `rd_ptr++`, `rem--`, read address = `rd_ptr+1` so the next byte is present the following cycle.
    - On handshake with `out_last` → IDLE.
  - No handshake: `out_data`, `out_last` and `out_len` are held.
- **RAM.** Simple dual-port, registered read. A write and a read may target different addresses in the same cycle. They never hit the same address, because reads touch only committed bytes.

## Timing
- **Reset values:** all pointers 0; length queue empty; FSM IDLE; `out_valid`=0, `out_last`=0, `out_data`=0, `out_len`=0, `frames_dropped`=0, `buf_full`=0.
- **Commit latency:** `out_valid` rises 2 cycles after the clock edge that commits the frame (edge N commits; N+1 IDLE pop; N+2 SEND).
- **Frame-to-frame gap:** 2 cycles minimum between the last handshake of one frame and `out_valid` of the next (IDLE, FETCH).
- **Throughput:** 1 byte/cycle sustained in SEND with `out_ready`=1.
- **Space release:** space freed by a read is visible to the writer on the next cycle.
- **Reset mid-operation:** asynchronous reset discards all stored and partial frames immediately. `out_valid` drops in the same instant.
- **Input timing:** `in_bad`/`in_last` are ignored when `in_valid`=0. Back-to-back frames with zero idle cycles are legal.

## Test plan
- **Single good frame:** one 64-byte frame, `in_bad`=0, `out_ready`=1 → `out_len`=64; 64 bytes out in order; `out_valid` 2 cycles after commit; `out_last` on byte 64 only.
- **Bad frame:** 60-byte frame with `in_bad`=1 on last, then a good 64-byte frame → only the 64-byte frame emitted; `frames_dropped`=1; `wr_ptr` returned to pre-frame value.
- **Overflow:** `ADDR_W`=6 (63 usable), `out_ready`=0, 40-byte good frame then 40-byte frame → second dropped; `frames_dropped`=1; after releasing `out_ready`, first frame intact with `out_len`=40.
- **Backpressure and wrap:** 20 frames of 100 bytes with `ADDR_W`=8, random `out_ready` → every byte matches the scoreboard across pointer wrap; `out_data` held while `out_ready`=0.
- **Length-queue full:** `LQ_W`=2, `out_ready`=0, five 10-byte good frames → four stored, fifth dropped; `frames_dropped`=1.
- **Reset mid-frame:** assert `rst_n`=0 during byte 30 of a 64-byte frame, then send a 64-byte frame → outputs zero during reset; only the new frame replayed, `out_len`=64.
